// File: rtl/l2_line_bridge_pkg.sv
// Shared LC-3b cache types plus the L2 line bridge state encoding and sizing constants.
package lc3b_types;

  localparam int unsigned L2_BRIDGE_BEATS  = 4;
  localparam int unsigned L2_BRIDGE_BEAT_W = 64;
  localparam int unsigned L2_ADDR_W        = 16;

  typedef logic [255:0] lc3b_cacheline;
  typedef logic [63:0]  lc3b_pmem_beat;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } l2_bridge_state_t;

endpackage

// File: rtl/l2_line_bridge_line_buffer.sv
// One cacheline register: full-line load, beat-indexed write, beat-indexed read.
// line_c / rd_beat_c expose the value the register takes at the next edge.
module l2_line_buffer
  import lc3b_types::*;
#(
  parameter int unsigned BEATS  = L2_BRIDGE_BEATS,
  parameter int unsigned BEAT_W = L2_BRIDGE_BEAT_W,
  parameter int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_en,
  input  logic [BEATS*BEAT_W-1:0] load_line,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [BEAT_W-1:0]       wr_beat,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [BEATS*BEAT_W-1:0] line_c,
  output logic [BEAT_W-1:0]       rd_beat_c
);

  logic [BEATS-1:0][BEAT_W-1:0] line_q;
  logic [BEATS-1:0][BEAT_W-1:0] line_d;

  // Full-line load takes priority over a single-beat write
  always_comb begin
    line_d = line_q;
    if (load_en) begin
      line_d = load_line;
    end else if (wr_en) begin
      line_d[wr_idx] = wr_beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_c    = line_d;
  assign rd_beat_c = line_d[rd_idx];

endmodule

// File: rtl/l2_line_bridge.sv
// Serves 256-bit L1 line requests as bursts of narrow pmem beats.
// Optional pmem wait timeout with abort flag: define L2_BRIDGE_TIMEOUT_EN.
module l2_line_bridge
  import lc3b_types::*;
#(
  parameter int unsigned BEATS  = L2_BRIDGE_BEATS,
  parameter int unsigned BEAT_W = L2_BRIDGE_BEAT_W
`ifdef L2_BRIDGE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    l2_read,
  input  logic                    l2_write,
  input  logic [15:0]             l2_address,
  input  logic [BEATS*BEAT_W-1:0] l2_wdata,
  output logic [BEATS*BEAT_W-1:0] l2_rdata,
  output logic                    l2_resp,
  output logic                    l2_err,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [15:0]             pmem_address,
  output logic [BEAT_W-1:0]       pmem_wdata,
  input  logic [BEAT_W-1:0]       pmem_rdata,
  input  logic                    pmem_resp
);

  localparam int unsigned LINE_W     = BEATS * BEAT_W;
  localparam int unsigned IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFFSET_W   = $clog2(LINE_W / 8);
  localparam int unsigned BEAT_BYTES = BEAT_W / 8;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  l2_bridge_state_t state_q, state_d;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic [15:0]      base_q, base_d;
  logic             buf_load, buf_wr;
  logic [LINE_W-1:0] line_c;
  logic [BEAT_W-1:0] rd_beat_c;

  logic              l2_resp_d, pmem_read_d, pmem_write_d, rdata_load;
  logic [15:0]       pmem_address_d;
  logic [BEAT_W-1:0] pmem_wdata_d;

  // Line offset bits never reach pmem: bursts always start line-aligned
  logic unused_offset_bits;
  assign unused_offset_bits = ^l2_address[OFFSET_W-1:0];

`ifdef L2_BRIDGE_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_hit;
  logic              l2_err_d;
`endif

  l2_line_buffer #(
    .BEATS (BEATS),
    .BEAT_W(BEAT_W),
    .IDX_W (IDX_W)
  ) u_line_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (buf_load),
    .load_line(l2_wdata),
    .wr_en    (buf_wr),
    .wr_idx   (beat_q),
    .wr_beat  (pmem_rdata),
    .rd_idx   (beat_d),
    .line_c   (line_c),
    .rd_beat_c(rd_beat_c)
  );

  // State, beat counter, burst base (and wait counter)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
`ifdef L2_BRIDGE_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
`ifdef L2_BRIDGE_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  // Next state; read wins over write when both are requested in IDLE
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    base_d   = base_q;
    buf_load = 1'b0;
    buf_wr   = 1'b0;
`ifdef L2_BRIDGE_TIMEOUT_EN
    wait_d      = '0;
    timeout_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (l2_read) begin
          base_d  = {l2_address[15:OFFSET_W], OFFSET_W'(0)};
          beat_d  = '0;
          state_d = READ;
        end else if (l2_write) begin
          base_d   = {l2_address[15:OFFSET_W], OFFSET_W'(0)};
          beat_d   = '0;
          buf_load = 1'b1;
          state_d  = WRITE;
        end
      end
      READ, WRITE: begin
        if (pmem_resp) begin
          buf_wr = (state_q == READ);
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + IDX_W'(1);
          end
        end
`ifdef L2_BRIDGE_TIMEOUT_EN
        else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_d == WAIT_W'(TIMEOUT)) begin
            state_d     = DONE;
            timeout_hit = 1'b1;
          end
        end
`endif
      end
      DONE: begin
        beat_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    l2_resp_d      = (state_d == DONE);
    pmem_read_d    = (state_d == READ);
    pmem_write_d   = (state_d == WRITE);
    pmem_address_d = '0;
    pmem_wdata_d   = '0;
    rdata_load     = (state_q == READ) && (state_d == DONE);
    if (pmem_read_d || pmem_write_d) begin
      pmem_address_d = base_d + 16'(beat_d) * 16'(BEAT_BYTES);
    end
    if (pmem_write_d) begin
      pmem_wdata_d = rd_beat_c;
    end
`ifdef L2_BRIDGE_TIMEOUT_EN
    l2_err_d = (state_d == DONE) && timeout_hit;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l2_rdata     <= '0;
      l2_resp      <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      l2_resp      <= l2_resp_d;
      pmem_read    <= pmem_read_d;
      pmem_write   <= pmem_write_d;
      pmem_address <= pmem_address_d;
      pmem_wdata   <= pmem_wdata_d;
      if (rdata_load) begin
        l2_rdata <= line_c;
      end
    end
  end

`ifdef L2_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l2_err <= 1'b0;
    end else begin
      l2_err <= l2_err_d;
    end
  end
`else
  assign l2_err = 1'b0;
`endif

endmodule

// File: tb/tb_l2_line_bridge.sv
// Directed bench for l2_line_bridge: reads, writes, pmem wait states, mid-burst reset.
module tb_l2_line_bridge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         l2_read, l2_write;
  logic [15:0]  l2_address;
  logic [255:0] l2_wdata;
  logic [255:0] l2_rdata;
  logic         l2_resp, l2_err;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  int n_checks = 0;
  int n_fail   = 0;
  logic [255:0] last_rd;

  always #5 clk = ~clk;

`ifdef L2_BRIDGE_TIMEOUT_EN
  l2_line_bridge #(.TIMEOUT(8)) dut (
`else
  l2_line_bridge dut (
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .l2_read     (l2_read),
    .l2_write    (l2_write),
    .l2_address  (l2_address),
    .l2_wdata    (l2_wdata),
    .l2_rdata    (l2_rdata),
    .l2_resp     (l2_resp),
    .l2_err      (l2_err),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " pmem_read"},    256'(pmem_read),    256'(0));
    check({tag, " pmem_write"},   256'(pmem_write),   256'(0));
    check({tag, " pmem_address"}, 256'(pmem_address), 256'(0));
    check({tag, " pmem_wdata"},   256'(pmem_wdata),   256'(0));
    check({tag, " l2_resp"},      256'(l2_resp),      256'(0));
    check({tag, " l2_err"},       256'(l2_err),       256'(0));
    check({tag, " l2_rdata"},     l2_rdata,           256'(0));
  endtask

  // One line transaction, called at a negedge; pmem answers beat b after dN wait cycles
  task automatic do_burst(input string tag, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [255:0] wline,
                          input logic [255:0] mline,
                          input int d0, input int d1, input int d2, input int d3);
    int dly [4];
    int cyc;
    int total;
    logic is_wr;
    logic [15:0] base;
    dly   = '{d0, d1, d2, d3};
    is_wr = !rd && wr;
    base  = {addr[15:5], 5'b0};
    total = 6 + d0 + d1 + d2 + d3;
    l2_read    = rd;
    l2_write   = wr;
    l2_address = addr;
    l2_wdata   = wline;
    cyc = 1;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k <= dly[b]; k++) begin
        @(negedge clk);
        cyc++;
        l2_address = ~addr;
        l2_wdata   = ~wline;
        check($sformatf("%s b%0d w%0d pmem_read", tag, b, k), 256'(pmem_read), 256'(!is_wr));
        check($sformatf("%s b%0d w%0d pmem_write", tag, b, k), 256'(pmem_write), 256'(is_wr));
        check($sformatf("%s b%0d w%0d pmem_address", tag, b, k), 256'(pmem_address),
              256'(base + 16'(b * 8)));
        if (is_wr)
          check($sformatf("%s b%0d w%0d pmem_wdata", tag, b, k), 256'(pmem_wdata),
                256'(wline[b*64 +: 64]));
        check($sformatf("%s b%0d w%0d l2_resp", tag, b, k), 256'(l2_resp), 256'(0));
        if (k == dly[b]) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mline[b*64 +: 64];
        end else begin
          pmem_resp  = 1'b0;
          pmem_rdata = {$urandom, $urandom};
        end
      end
    end
    @(negedge clk);
    cyc++;
    pmem_resp = 1'b0;
    check({tag, " resp"},        256'(l2_resp),    256'(1));
    check({tag, " err"},         256'(l2_err),     256'(0));
    check({tag, " rd strobe off"}, 256'(pmem_read),  256'(0));
    check({tag, " wr strobe off"}, 256'(pmem_write), 256'(0));
    check({tag, " resp cycle"},  256'(cyc),        256'(total));
    if (!is_wr) last_rd = mline;
    check({tag, " rdata"},       l2_rdata,         last_rd);
    l2_read  = 1'b0;
    l2_write = 1'b0;
    @(negedge clk);
    check({tag, " resp single"}, 256'(l2_resp), 256'(0));
    check({tag, " idle strobe"}, 256'(pmem_read | pmem_write), 256'(0));
  endtask

  initial begin
    logic [255:0] rline;
    logic [255:0] wline;
    rst_n      = 1'b0;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    last_rd    = '0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post reset idle");

    // Zero-wait read from 0x1234 -> beats at 0x1220..0x1238
    rline = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
             64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
    do_burst("read0", 1'b1, 1'b0, 16'h1234, 256'(0), rline, 0, 0, 0, 0);

    // Zero-wait write; l2_rdata must keep the previous read line
    wline = {64'hdddd_cccc_bbbb_aaaa, 64'h0f1e_2d3c_4b5a_6978,
             64'hfedc_ba98_7654_3210, 64'h0123_4567_89ab_cdef};
    do_burst("write0", 1'b0, 1'b1, 16'hABE0, wline, 256'(0), 0, 0, 0, 0);

    // Read and write together: only the read is served
    rline = {64'h0bad_f00d_0000_0004, 64'h0bad_f00d_0000_0003,
             64'h0bad_f00d_0000_0002, 64'h0bad_f00d_0000_0001};
    do_burst("both", 1'b1, 1'b1, 16'h7FFF, wline, rline, 0, 0, 0, 0);

    // Fixed wait states, then random wait states
    rline = {64'h8877_6655_4433_2211, 64'h1020_3040_5060_7080,
             64'hcafe_babe_dead_beef, 64'h0000_ffff_0000_ffff};
    do_burst("readw", 1'b1, 1'b0, 16'hFFE5, 256'(0), rline, 2, 0, 5, 1);
    for (int i = 0; i < 3; i++) begin
      rline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      wline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_burst($sformatf("rnd_rd%0d", i), 1'b1, 1'b0, 16'($urandom), 256'(0), rline,
               $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      do_burst($sformatf("rnd_wr%0d", i), 1'b0, 1'b1, 16'($urandom), wline, 256'(0),
               $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
    end

    // Reset asserted while beat 2 of a read is pending
    l2_read    = 1'b1;
    l2_address = 16'h4460;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      check($sformatf("rst b%0d addr", b), 256'(pmem_address), 256'(16'h4460 + 16'(b * 8)));
      pmem_resp  = 1'b1;
      pmem_rdata = 64'h5555_0000_0000_0000 + 64'(b);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    check("rst b2 addr", 256'(pmem_address), 256'(16'h4470));
    check("rst b2 strobe", 256'(pmem_read), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid-burst reset");
    l2_read = 1'b0;
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("after rst %0d resp", i), 256'(l2_resp), 256'(0));
      check($sformatf("after rst %0d strobe", i), 256'(pmem_read | pmem_write), 256'(0));
    end
    rline = {64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
             64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
    do_burst("read after rst", 1'b1, 1'b0, 16'h4460, 256'(0), rline, 1, 0, 0, 2);

`ifdef L2_BRIDGE_TIMEOUT_EN
    // pmem never answers: abort after 8 unanswered strobe cycles
    l2_read    = 1'b1;
    l2_address = 16'h2000;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i < 9) begin
        check($sformatf("tmo c%0d resp", i), 256'(l2_resp), 256'(0));
        check($sformatf("tmo c%0d strobe", i), 256'(pmem_read), 256'(1));
      end else begin
        check("tmo resp", 256'(l2_resp), 256'(1));
        check("tmo err", 256'(l2_err), 256'(1));
        check("tmo strobe off", 256'(pmem_read), 256'(0));
      end
    end
    l2_read = 1'b0;
    @(negedge clk);
    check("tmo resp single", 256'(l2_resp), 256'(0));
    check("tmo err single", 256'(l2_err), 256'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
